ram_loader: RTL and testbench

Write-side sequencer that sits directly upstream of the operand/result `ram`. It accepts a byte stream from the host over a valid/ready handshake and writes it in order into the ram. The first 16 bytes go to A00..A33 at addresses 0..15; the next 9 go to B00..B22 at addresses 16..24. It then pulses `start` to the systolic array, accepts the four convolution results back over a second handshake into C00..C11 (addresses 25..28), and signals frame completion. It is the only driver of the ram's `en`/`addr`/`in` port.

---
 rtl/ram_loader.sv | 117 +++++++++++
 tb/tb_ram_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: write-side sequencer in front of the operand/result ram.
// It takes N_OPS operand bytes from the host stream and writes them to
// addresses 0..N_OPS-1. It then pulses start to the array and accepts N_RES
// result bytes, which it writes to addresses N_OPS..N_OPS+N_RES-1. Finally it
// pulses done and returns to accept the next frame.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_valid/s_data/s_ready        host operand byte handshake
//   res_valid/res_data/res_ready  array result byte handshake
//   ram_en/ram_addr/ram_in        ram write port (sole driver)
//   start                one-cycle pulse, operands resident in ram
//   done                 one-cycle pulse, all results written
module ram_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int N_OPS  = 25,
  parameter int N_RES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              start,
  output logic              done
);

  typedef enum logic [1:0] {LOAD, KICK, COLLECT, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_OP  = ADDR_W'(N_OPS - 1);
  localparam logic [ADDR_W-1:0] RES_BASE = ADDR_W'(N_OPS);
  localparam logic [ADDR_W-1:0] LAST_RES = ADDR_W'(N_OPS + N_RES - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  // Counts cycles in KICK/FIN: 0 lets the final write land, 1 raises the
  // pulse, 2 drops it and moves on.
  logic [1:0]        wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      wait_cnt  <= '0;
      s_ready   <= 1'b0;
      res_ready <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_in    <= '0;
      start     <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_en <= 1'b0;
      start  <= 1'b0;
      done   <= 1'b0;
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            ram_en   <= 1'b1;
            ram_addr <= idx;
            ram_in   <= s_data;
            if (idx == LAST_OP) begin
              s_ready  <= 1'b0;
              wait_cnt <= '0;
              state    <= KICK;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        KICK: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == 2'd1) start <= 1'b1;
          if (wait_cnt == 2'd2) begin
            wait_cnt  <= '0;
            idx       <= RES_BASE;
            res_ready <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (res_valid && res_ready) begin
            ram_en   <= 1'b1;
            ram_addr <= idx;
            ram_in   <= res_data;
            if (idx == LAST_RES) begin
              res_ready <= 1'b0;
              wait_cnt  <= '0;
              state     <= FIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FIN: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == 2'd1) done <= 1'b1;
          if (wait_cnt == 2'd2) begin
            wait_cnt <= '0;
            idx      <= '0;
            s_ready  <= 1'b1;
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a behavioural ram captures every write, a
// monitor logs handshakes and pulses by edge number, and each test task
// compares the log against hand-computed values.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = '0;
  logic       res_ready;
  logic       ram_en;
  logic [4:0] ram_addr;
  logic [7:0] ram_in;
  logic       start;
  logic       done;

  int n_checks = 0;
  int n_pass = 0;

  ram_loader #(.DATA_W(8), .ADDR_W(5), .N_OPS(25), .N_RES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_in(ram_in),
    .start(start), .done(done)
  );

  always #5 clk = ~clk;

  // Ram model and event monitor (values sampled are the pre-edge values).
  logic [7:0] mem [32];
  int cyc = 0;
  int n_s_acc = 0, n_r_acc = 0, n_start = 0, n_done = 0;
  int last_s_acc = 0, last_r_acc = 0, start_cyc = 0, done_cyc = 0;
  int wr_addr[$], wr_data[$], wr_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (ram_en) begin
      mem[ram_addr] = ram_in;
      wr_addr.push_back(int'(ram_addr));
      wr_data.push_back(int'(ram_in));
      wr_cyc.push_back(cyc);
    end
    if (start) begin n_start++; start_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (s_valid && s_ready) begin n_s_acc++; last_s_acc = cyc; end
    if (res_valid && res_ready) begin n_r_acc++; last_r_acc = cyc; end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic send_ops(input logic [7:0] base, input int n, input bit stall, output bit ok);
    int a0 = n_s_acc;
    int t = 0;
    int i;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      i = n_s_acc - a0;
      if (i >= n) break;
      t++;
      if (t > 400) begin ok = 1'b0; break; end
      if (stall && (t % 3 == 0)) s_valid = 1'b0;
      else begin s_valid = 1'b1; s_data = base + 8'(i); end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_res(input logic [7:0] base, input bit stall, output bit ok);
    int a0 = n_r_acc;
    int t = 0;
    int i;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      i = n_r_acc - a0;
      if (i >= 4) break;
      t++;
      if (t > 400) begin ok = 1'b0; break; end
      if (stall && (t % 2 == 0)) res_valid = 1'b0;
      else begin res_valid = 1'b1; res_data = base + 8'(i); end
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_count(input int which, input int target, output bit ok);
    int t = 0;
    ok = 1'b1;
    while (((which == 0) ? n_start : n_done) < target) begin
      @(negedge clk);
      t++;
      if (t > 50) begin ok = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_ready, res_ready, ram_en, ram_addr, ram_in, start, done} !== 20'h0)
      $display("FAIL reset_outputs: got %0h want 0", {s_ready, res_ready, ram_en, ram_addr, ram_in, start, done});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", s_ready);
    else n_pass++;
    n_checks++;
    if (res_ready !== 1'b0) $display("FAIL res_ready_in_load: got %b want 0", res_ready);
    else n_pass++;
  endtask

  task automatic test_stream();
    bit ok;
    int s0 = n_start;
    clear_log();
    send_ops(8'h00, 25, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL stream_timeout: got timeout want 25 accepts");
    else n_pass++;
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL s_ready_in_kick: got %b want 0", s_ready);
    else n_pass++;
    wait_count(0, s0 + 1, ok);
    n_checks++;
    if (!ok) $display("FAIL start_timeout: got no start want 1 pulse");
    else n_pass++;
    n_checks++;
    if (wr_addr.size() != 25) $display("FAIL stream_write_count: got %0d want 25", wr_addr.size());
    else n_pass++;
    for (int i = 0; i < 25 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i || wr_data[i] != i)
        $display("FAIL stream_write[%0d]: got addr %0d data %0d want %0d/%0d", i, wr_addr[i], wr_data[i], i, i);
      else n_pass++;
    end
    n_checks++;
    if (wr_addr.size() == 25 && wr_cyc[24] - wr_cyc[0] != 24)
      $display("FAIL stream_consecutive: got span %0d want 24", wr_cyc[24] - wr_cyc[0]);
    else n_pass++;
    n_checks++;
    if (start_cyc - last_s_acc != 3)
      $display("FAIL start_latency: got %0d edges want 3", start_cyc - last_s_acc);
    else n_pass++;
    n_checks++;
    if (res_ready !== 1'b1 || start !== 1'b0)
      $display("FAIL after_start: got res_ready %b start %b want 1/0", res_ready, start);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_start - s0 != 1) $display("FAIL start_once: got %0d want 1", n_start - s0);
    else n_pass++;
  endtask

  task automatic test_results();
    bit ok;
    int d0 = n_done;
    clear_log();
    send_res(8'hA0, 1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL results_timeout: got timeout want 4 accepts");
    else n_pass++;
    wait_count(1, d0 + 1, ok);
    n_checks++;
    if (!ok) $display("FAIL done_timeout: got no done want 1 pulse");
    else n_pass++;
    n_checks++;
    if (done_cyc - last_r_acc != 3) $display("FAIL done_latency: got %0d edges want 3", done_cyc - last_r_acc);
    else n_pass++;
    n_checks++;
    if (s_ready !== 1'b1 || res_ready !== 1'b0)
      $display("FAIL ready_after_done: got s %b res %b want 1/0", s_ready, res_ready);
    else n_pass++;
    n_checks++;
    if (wr_addr.size() != 4) $display("FAIL result_write_count: got %0d want 4", wr_addr.size());
    else n_pass++;
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (mem[25 + j] !== 8'hA0 + 8'(j))
        $display("FAIL result_mem[%0d]: got %0h want %0h", 25 + j, mem[25 + j], 8'hA0 + 8'(j));
      else n_pass++;
    end
  endtask

  task automatic test_no_consume_load();
    clear_log();
    res_valid = 1'b1;
    res_data = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_ready !== 1'b0) $display("FAIL res_ready_in_load[%0d]: got %b want 0", i, res_ready);
      else n_pass++;
    end
    res_valid = 1'b0;
    n_checks++;
    if (wr_addr.size() != 0 || n_r_acc != 4)
      $display("FAIL load_spurious: got %0d writes %0d res accepts want 0/4", wr_addr.size(), n_r_acc);
    else n_pass++;
  endtask

  task automatic test_stall_stream();
    bit ok;
    int s0 = n_start, d0 = n_done, a0 = n_s_acc;
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    clear_log();
    send_ops(8'h00, 25, 1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL stall_timeout: got timeout want 25 accepts");
    else n_pass++;
    // Host keeps offering a byte through KICK/COLLECT; results start while
    // still in KICK, so res_valid is also high during the start pulse.
    s_valid = 1'b1;
    s_data = 8'hEE;
    send_res(8'hB0, 1'b0, ok);
    s_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL stall_results_timeout: got timeout want 4 accepts");
    else n_pass++;
    wait_count(1, d0 + 1, ok);
    n_checks++;
    if (!ok) $display("FAIL stall_done_timeout: got no done want 1 pulse");
    else n_pass++;
    n_checks++;
    if (n_s_acc - a0 != 25) $display("FAIL stall_s_accepts: got %0d want 25", n_s_acc - a0);
    else n_pass++;
    n_checks++;
    if (n_start - s0 != 1) $display("FAIL stall_start_once: got %0d want 1", n_start - s0);
    else n_pass++;
    n_checks++;
    if (wr_addr.size() != 29) $display("FAIL stall_write_count: got %0d want 29", wr_addr.size());
    else n_pass++;
    for (int i = 0; i < 29 && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] != i) $display("FAIL stall_addr[%0d]: got %0d want %0d", i, wr_addr[i], i);
      else n_pass++;
    end
    for (int i = 0; i < 25; i++) begin
      n_checks++;
      if (mem[i] !== 8'(i)) $display("FAIL stall_mem[%0d]: got %0h want %0h", i, mem[i], i);
      else n_pass++;
    end
    n_checks++;
    if (mem[25] !== 8'hB0 || mem[28] !== 8'hB3)
      $display("FAIL stall_res_mem: got %0h/%0h want b0/b3", mem[25], mem[28]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    send_ops(8'h40, 10, 1'b0, ok);
    n_checks++;
    if (!ok || ram_en !== 1'b1) $display("FAIL mid_prefill: got ok %b ram_en %b want 1/1", ok, ram_en);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, res_ready, ram_en, ram_addr, ram_in, start, done} !== 20'h0)
      $display("FAIL mid_reset_outputs: got %0h want 0", {s_ready, res_ready, ram_en, ram_addr, ram_in, start, done});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_addr.size() != 9) $display("FAIL mid_partial_write: got %0d writes want 9", wr_addr.size());
    else n_pass++;
    rst_n = 1'b1;
    send_ops(8'h55, 1, 1'b0, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || wr_addr.size() != 10 || wr_addr[wr_addr.size() - 1] != 0 || wr_data[wr_data.size() - 1] != 8'h55)
      $display("FAIL mid_first_byte: got %0d writes last addr %0d data %0h want 10/0/55",
               wr_addr.size(), wr_addr[wr_addr.size() - 1], wr_data[wr_data.size() - 1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok;
    int s0 = n_start, d0 = n_done;
    all_ok = 1'b1;
    send_ops(8'h56, 24, 1'b0, ok);  all_ok &= ok;
    send_res(8'hC0, 1'b0, ok);      all_ok &= ok;
    send_ops(8'h80, 25, 1'b0, ok);  all_ok &= ok;
    send_res(8'hD0, 1'b0, ok);      all_ok &= ok;
    wait_count(1, d0 + 2, ok);      all_ok &= ok;
    n_checks++;
    if (!all_ok) $display("FAIL b2b_timeout: got timeout want completion");
    else n_pass++;
    n_checks++;
    if (n_start - s0 != 2 || n_done - d0 != 2)
      $display("FAIL b2b_pulses: got start %0d done %0d want 2/2", n_start - s0, n_done - d0);
    else n_pass++;
    for (int i = 0; i < 25; i++) begin
      n_checks++;
      if (mem[i] !== 8'h80 + 8'(i)) $display("FAIL b2b_mem[%0d]: got %0h want %0h", i, mem[i], 8'h80 + 8'(i));
      else n_pass++;
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (mem[25 + j] !== 8'hD0 + 8'(j))
        $display("FAIL b2b_res[%0d]: got %0h want %0h", 25 + j, mem[25 + j], 8'hD0 + 8'(j));
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    test_reset();
    test_stream();
    test_results();
    test_no_consume_load();
    test_stall_stream();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
